ddr3_usr_write: RTL and testbench

Avalon-MM burst write master that takes a 256-bit word stream and writes it into DDR3 through the EMIF, starting at a programmed word address. It is the write-side counterpart of `ddr3_usr_logic`, which reads frames back out for HDMI playout. It sits between the pattern/frame loader (host or on-chip source) and the DDR3 EMIF user port, in the `mem_clk` domain.

---
 rtl/ddr3_usr_write_if.sv | 22 ++
 rtl/ddr3_usr_write.sv | 149 ++++++++++++++
 tb/tb_ddr3_usr_write.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_usr_write_if.sv
// Avalon-MM write-side bus between ddr3_usr_write and the DDR3 EMIF user port.
interface ddr3_usr_write_if;
   logic         ddr3_emif_ready;
   logic         ddr3_emif_write;
   logic         ddr3_emif_read;
   logic [21:0]  ddr3_emif_addr;
   logic [255:0] ddr3_emif_write_data;
   logic [31:0]  ddr3_emif_byte_enable;
   logic [4:0]   ddr3_emif_burst_count;

   modport master (
      input  ddr3_emif_ready,
      output ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr, ddr3_emif_write_data,
             ddr3_emif_byte_enable, ddr3_emif_burst_count
   );

   modport slave (
      output ddr3_emif_ready,
      input  ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr, ddr3_emif_write_data,
             ddr3_emif_byte_enable, ddr3_emif_burst_count
   );
endinterface

// File: rtl/ddr3_usr_write.sv
// Avalon-MM burst write master: buffers a 256-bit word stream and writes it to DDR3 in bursts.
// Define DDR3_WR_PARTIAL_BE_EN to mask the unused bytes of the job's final partial word.
module ddr3_usr_write #(
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                ddr3_emif_clk,
   input  logic                ddr3_emif_rst,
   input  logic                ddr3_write_start,
   input  logic [21:0]         ddr3_usr_start_addr_in,
   input  logic [31:0]         to_write_byte_in,
   output logic                ddr3_write_done_out,
   output logic                ddr3_write_busy_out,
   input  logic [255:0]        write_data_in,
   input  logic                write_data_valid_in,
   output logic                write_data_ready_out,
   ddr3_usr_write_if.master    emif
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

   state_e         state_q, state_d;
   logic [21:0]    addr_q, addr_d;
   logic [31:0]    remain_q, remain_d;
   logic [31:0]    total_q, total_d;
   logic [31:0]    accepted_q, accepted_d;
   logic [4:0]     burst_q, burst_d;
   logic [4:0]     beat_q, beat_d;
   logic [255:0]   mem [FIFO_DEPTH];
   logic [PtrW:0]  wr_ptr_q, rd_ptr_q, fill;
   logic [31:0]    words;
   logic [4:0]     b_size;
   logic           busy, full, push, pop, last_beat;

   assign words = {5'd0, to_write_byte_in[31:5]} + {31'd0, |to_write_byte_in[4:0]};
   assign fill  = wr_ptr_q - rd_ptr_q;
   assign full  = (fill == (PtrW + 1)'(FIFO_DEPTH));
   assign busy  = (state_q == StWait) || (state_q == StBurst);
   assign write_data_ready_out = busy && !full && (accepted_q < total_q);
   assign push  = write_data_valid_in && write_data_ready_out;
   assign pop   = emif.ddr3_emif_write && emif.ddr3_emif_ready;
   assign b_size = (remain_q >= 32'(BURST_LEN)) ? 5'(BURST_LEN) : remain_q[4:0];
   assign last_beat = (beat_q == burst_q - 5'd1);

   assign ddr3_write_busy_out          = busy;
   assign ddr3_write_done_out          = (state_q == StDone);
   assign emif.ddr3_emif_write         = (state_q == StBurst);
   assign emif.ddr3_emif_read          = 1'b0;
   assign emif.ddr3_emif_addr          = addr_q;
   assign emif.ddr3_emif_burst_count   = burst_q;
   assign emif.ddr3_emif_write_data    = (state_q == StBurst) ? mem[rd_ptr_q[PtrW-1:0]] : '0;

`ifdef DDR3_WR_PARTIAL_BE_EN
   logic [4:0] tail_q, tail_d;
   logic       job_last;
   assign job_last = (state_q == StBurst) && last_beat && (remain_q == 32'(burst_q));
   assign emif.ddr3_emif_byte_enable = (job_last && tail_q != 5'd0) ?
                                       ((32'd1 << tail_q) - 32'd1) : '1;
`else
   assign emif.ddr3_emif_byte_enable = '1;
`endif

   always_ff @(posedge ddr3_emif_clk) begin
      if (push) mem[wr_ptr_q[PtrW-1:0]] <= write_data_in;
   end

   always_ff @(posedge ddr3_emif_clk) begin
      if (ddr3_emif_rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         remain_q   <= '0;
         total_q    <= '0;
         accepted_q <= '0;
         burst_q    <= '0;
         beat_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
`ifdef DDR3_WR_PARTIAL_BE_EN
         tail_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         total_q    <= total_d;
         accepted_q <= accepted_d;
         burst_q    <= burst_d;
         beat_q     <= beat_d;
         wr_ptr_q   <= wr_ptr_q + (PtrW + 1)'(push);
         rd_ptr_q   <= rd_ptr_q + (PtrW + 1)'(pop);
`ifdef DDR3_WR_PARTIAL_BE_EN
         tail_q     <= tail_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      total_d    = total_q;
      accepted_d = accepted_q + 32'(push);
      burst_d    = burst_q;
      beat_d     = beat_q;
`ifdef DDR3_WR_PARTIAL_BE_EN
      tail_d     = tail_q;
`endif
      unique case (state_q)
         StIdle: begin
            // A zero-length job still passes through StWait so done lands two cycles after start.
            if (ddr3_write_start) begin
               total_d    = words;
               remain_d   = words;
               accepted_d = '0;
               addr_d     = ddr3_usr_start_addr_in;
`ifdef DDR3_WR_PARTIAL_BE_EN
               tail_d     = to_write_byte_in[4:0];
`endif
               state_d    = StWait;
            end
         end
         StWait: begin
            if (remain_q == 32'd0) begin
               state_d = StDone;
            end else if (32'(fill) >= 32'(b_size)) begin
               burst_d = b_size;
               beat_d  = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (pop) begin
               if (last_beat) begin
                  addr_d   = addr_q + 22'(burst_q);
                  remain_d = remain_q - 32'(burst_q);
                  state_d  = (remain_q == 32'(burst_q)) ? StDone : StWait;
               end else begin
                  beat_d = beat_q + 5'd1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_ddr3_usr_write.sv
// Self-checking bench for ddr3_usr_write: table of write jobs checked against a burst model.
module tb_ddr3_usr_write;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [21:0]  start_addr;
   logic [31:0]  nbytes;
   logic         done, busy;
   logic [255:0] wdata;
   logic         wvalid, wready;

   ddr3_usr_write_if bus ();

   ddr3_usr_write dut (
      .ddr3_emif_clk          (clk),
      .ddr3_emif_rst          (rst),
      .ddr3_write_start       (start),
      .ddr3_usr_start_addr_in (start_addr),
      .to_write_byte_in       (nbytes),
      .ddr3_write_done_out    (done),
      .ddr3_write_busy_out    (busy),
      .write_data_in          (wdata),
      .write_data_valid_in    (wvalid),
      .write_data_ready_out   (wready),
      .emif                   (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_word(input int tag, input int j);
      logic [31:0] w;
      w = {tag[15:0], j[15:0]};
      return {8{w}};
   endfunction

   typedef struct {
      logic [21:0] addr;
      logic [31:0] bytes;
      bit          rnd;
      bit          restart;
      int          abort;
      int          exp_bursts;
      logic [21:0] exp_last_addr;
      logic [4:0]  exp_last_bc;
      logic [31:0] exp_last_be;
   } vec_t;

   vec_t vecs[9];

   task automatic run_job(input vec_t v, input int tag);
      int w, cyc, beats, bursts, words_in, done_cyc, dones, last_cyc, burst_beat, cur_bc;
      int budget, overrun;
      bit prev_stall, aborted;
      logic [21:0]  prev_addr, exp_addr, last_addr;
      logic [4:0]   prev_bc, exp_bc, last_bc;
      logic [255:0] prev_data;
      logic [31:0]  prev_be, last_be, exp_be;
      w = int'((longint'(v.bytes) + 31) / 32);
      budget = w * 4 + 100;
      beats = 0; bursts = 0; words_in = 0; done_cyc = -1; dones = 0; last_cyc = -1;
      burst_beat = 0; cur_bc = 0; overrun = 0; prev_stall = 0; aborted = 0;
      last_addr = '0; last_bc = '0; last_be = '0;
      prev_addr = '0; prev_bc = '0; prev_data = '0; prev_be = '0;
      @(negedge clk);
      start = 1'b1; start_addr = v.addr; nbytes = v.bytes;
      cyc = 0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = (v.restart && cyc == 3);
         start_addr = 22'h0; nbytes = 32'd64;
         if (cyc == 1) chk($sformatf("job%0d busy_after_start", tag), busy, 1'b1);
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc > done_cyc + 3) break;
         if (prev_stall) begin
            chk($sformatf("job%0d hold_write", tag), bus.ddr3_emif_write, 1'b1);
            chk($sformatf("job%0d hold_addr", tag), bus.ddr3_emif_addr, prev_addr);
            chk($sformatf("job%0d hold_bc", tag), bus.ddr3_emif_burst_count, prev_bc);
            chk($sformatf("job%0d hold_data", tag), bus.ddr3_emif_write_data, prev_data);
            chk($sformatf("job%0d hold_be", tag), bus.ddr3_emif_byte_enable, prev_be);
         end
         if (v.abort != 0 && beats == v.abort && bus.ddr3_emif_write) begin
            rst = 1'b1; wvalid = 1'b0; bus.ddr3_emif_ready = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk($sformatf("job%0d abort_write", tag), bus.ddr3_emif_write, 1'b0);
            chk($sformatf("job%0d abort_busy", tag), busy, 1'b0);
            chk($sformatf("job%0d abort_ready", tag), wready, 1'b0);
            dones = 0;
            repeat (5) begin
               if (done) dones++;
               @(negedge clk);
            end
            chk($sformatf("job%0d abort_no_done", tag), dones, 0);
            aborted = 1;
            break;
         end
         bus.ddr3_emif_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         wvalid = (words_in < w);
         wdata  = mk_word(tag, words_in);
         if (wready && words_in >= w) overrun++;
         if (wvalid && wready) words_in++;
         if (bus.ddr3_emif_write) begin
            if (burst_beat == 0 && !prev_stall) begin
               exp_addr = v.addr + 22'(bursts * 16);
               exp_bc   = ((w - bursts * 16) >= 16) ? 5'd16 : 5'(w - bursts * 16);
               chk($sformatf("job%0d burst%0d_addr", tag, bursts), bus.ddr3_emif_addr, exp_addr);
               chk($sformatf("job%0d burst%0d_bc", tag, bursts), bus.ddr3_emif_burst_count,
                   exp_bc);
               cur_bc = int'(bus.ddr3_emif_burst_count);
               last_addr = bus.ddr3_emif_addr;
               last_bc = bus.ddr3_emif_burst_count;
               bursts++;
            end
            if (bus.ddr3_emif_ready) begin
               chk($sformatf("job%0d beat%0d_data", tag, beats), bus.ddr3_emif_write_data,
                   mk_word(tag, beats));
               if (beats == w - 1) begin
                  last_be = bus.ddr3_emif_byte_enable;
               end else begin
                  exp_be = '1;
                  chk($sformatf("job%0d beat%0d_be", tag, beats), bus.ddr3_emif_byte_enable,
                      exp_be);
               end
               beats++;
               burst_beat++;
               if (burst_beat >= cur_bc) burst_beat = 0;
               last_cyc = cyc;
            end
            prev_stall = !bus.ddr3_emif_ready;
            prev_addr = bus.ddr3_emif_addr;
            prev_bc   = bus.ddr3_emif_burst_count;
            prev_data = bus.ddr3_emif_write_data;
            prev_be   = bus.ddr3_emif_byte_enable;
         end else begin
            prev_stall = 1'b0;
         end
      end
      wvalid = 1'b0; start = 1'b0;
      if (aborted) return;
      chk($sformatf("job%0d done_count", tag), dones, 1);
      chk($sformatf("job%0d beats", tag), beats, w);
      chk($sformatf("job%0d words_in", tag), words_in, w);
      chk($sformatf("job%0d ready_overrun", tag), overrun, 0);
      chk($sformatf("job%0d bursts", tag), bursts, v.exp_bursts);
      if (w == 0) chk($sformatf("job%0d zero_done_lat", tag), done_cyc, 2);
      else        chk($sformatf("job%0d done_lat", tag), done_cyc, last_cyc + 1);
      if (v.exp_bursts > 0) begin
         chk($sformatf("job%0d last_addr", tag), last_addr, v.exp_last_addr);
         chk($sformatf("job%0d last_bc", tag), last_bc, v.exp_last_bc);
`ifdef DDR3_WR_PARTIAL_BE_EN
         chk($sformatf("job%0d last_be", tag), last_be, v.exp_last_be);
`else
         chk($sformatf("job%0d last_be", tag), last_be, 32'hFFFF_FFFF);
`endif
      end
   endtask

   initial begin
      //           addr       bytes    rnd rst abort bursts last_addr  bc     last_be (partial)
      vecs[0] = '{22'h8,      1024,   0, 0, 0, 2,   22'h18,     5'd16, 32'hFFFF_FFFF};
      vecs[1] = '{22'h8,      259200, 1, 0, 0, 507, 22'h1FA8,   5'd4,  32'hFFFF_FFFF};
      vecs[2] = '{22'h100,    100,    0, 0, 0, 1,   22'h100,    5'd4,  32'h0000_000F};
      vecs[3] = '{22'h0,      0,      0, 0, 0, 0,   22'h0,      5'd0,  32'h0};
      vecs[4] = '{22'h40,     1024,   1, 1, 0, 2,   22'h50,     5'd16, 32'hFFFF_FFFF};
      vecs[5] = '{22'h3FFFF8, 1024,   0, 0, 0, 2,   22'h000008, 5'd16, 32'hFFFF_FFFF};
      vecs[6] = '{22'h20,     1024,   0, 0, 5, 0,   22'h0,      5'd0,  32'h0};
      vecs[7] = '{22'h200,    512,    0, 0, 0, 1,   22'h200,    5'd16, 32'hFFFF_FFFF};
      vecs[8] = '{22'h10,     33,     1, 0, 0, 1,   22'h10,     5'd2,  32'h0000_0001};

      rst = 1'b1; start = 1'b0; start_addr = '0; nbytes = '0;
      wdata = '0; wvalid = 1'b0; bus.ddr3_emif_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_write", bus.ddr3_emif_write, 1'b0);
      chk("reset_read", bus.ddr3_emif_read, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ready", wready, 1'b0);
      chk("reset_addr", bus.ddr3_emif_addr, 22'h0);
      chk("reset_bc", bus.ddr3_emif_burst_count, 5'h0);
      chk("reset_data", bus.ddr3_emif_write_data, 256'h0);
      chk("reset_be", bus.ddr3_emif_byte_enable, 32'hFFFF_FFFF);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_job(vecs[i], i + 1);
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
